// File: rtl/id_stage_pipe.sv
// RV32I/RV64I decode stage with a registered ID/EX entry: valid/ready toward IF and EX,
// flush, and a load-use hazard stall with a saturating stall-cycle counter.
module id_stage_pipe #(
  parameter int XLEN        = 64,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [31:0]            inst_i,
  input  logic [XLEN-1:0]        pc_i,
  output logic [4:0]             rs1_addr_o,
  output logic [4:0]             rs2_addr_o,
  input  logic [XLEN-1:0]        rs1_data_i,
  input  logic [XLEN-1:0]        rs2_data_i,
  input  logic                   ex_load_valid_i,
  input  logic [4:0]             ex_load_rd_i,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            inst_o,
  output logic [XLEN-1:0]        pc_o,
  output logic [XLEN-1:0]        op1_o,
  output logic [XLEN-1:0]        op2_o,
  output logic [XLEN-1:0]        imm_o,
  output logic [XLEN-1:0]        rs1_val_o,
  output logic [XLEN-1:0]        rs2_val_o,
  output logic [4:0]             rd_addr_o,
  output logic                   reg_wen_o,
  output logic                   mem_ren_o,
  output logic                   mem_wen_o,
  output logic                   word_op_o,
  output logic                   illegal_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  localparam bit         IS64       = (XLEN == 64);
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011, OPC_OP_IMM32 = 7'b0011011,
                         OPC_OP     = 7'b0110011, OPC_OP32     = 7'b0111011,
                         OPC_LOAD   = 7'b0000011, OPC_STORE    = 7'b0100011,
                         OPC_BRANCH = 7'b1100011, OPC_JAL      = 7'b1101111,
                         OPC_JALR   = 7'b1100111, OPC_LUI      = 7'b0110111,
                         OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc, op1, op2, imm, rs1_val, rs2_val;
    logic [4:0]      rd;
    logic            reg_wen, mem_ren, mem_wen, word_op, illegal;
  } id_ex_t;

  id_ex_t          dec, q;
  logic            vld_q, rs1_use, rs2_use, has_rd, is_shift, hazard, capture;
  logic [2:0]      f3;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, j_imm, u_imm, shamt, shamt_w;

  assign f3       = inst_i[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign i_imm    = XLEN'($signed(inst_i[31:20]));
  assign s_imm    = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign b_imm    = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign j_imm    = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  assign u_imm    = XLEN'($signed({inst_i[31:12], 12'h000}));
  assign shamt    = IS64 ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
  assign shamt_w  = XLEN'(inst_i[24:20]);

  always_comb begin
    dec         = '0;
    dec.inst    = inst_i;
    dec.pc      = pc_i;
    dec.rs1_val = rs1_data_i;
    dec.rs2_val = rs2_data_i;
    rs1_use     = 1'b0;
    rs2_use     = 1'b0;
    has_rd      = 1'b0;
    case (inst_i[6:0])
      OPC_OP_IMM, OPC_OP_IMM32: begin
        rs1_use = 1'b1; has_rd = 1'b1;
        dec.op1 = rs1_data_i;
        dec.imm = i_imm;
        if (inst_i[6:0] == OPC_OP_IMM32) begin
          dec.op2     = is_shift ? shamt_w : i_imm;
          dec.word_op = 1'b1;
          dec.illegal = !IS64;
        end else begin
          dec.op2     = is_shift ? shamt : i_imm;
          dec.illegal = !IS64 && is_shift && inst_i[25];
        end
      end
      OPC_OP, OPC_OP32: begin
        rs1_use = 1'b1; rs2_use = 1'b1; has_rd = 1'b1;
        dec.op1 = rs1_data_i;
        dec.op2 = rs2_data_i;
        if (inst_i[6:0] == OPC_OP32) begin
          dec.word_op = 1'b1;
          dec.illegal = !IS64;
        end
      end
      OPC_LOAD: begin
        rs1_use = 1'b1; has_rd = 1'b1;
        dec.op1 = rs1_data_i; dec.op2 = i_imm; dec.imm = i_imm;
        dec.mem_ren = 1'b1;
      end
      OPC_STORE: begin
        rs1_use = 1'b1; rs2_use = 1'b1;
        dec.op1 = rs1_data_i; dec.op2 = s_imm; dec.imm = s_imm;
        dec.mem_wen = 1'b1;
      end
      OPC_BRANCH: begin
        rs1_use = 1'b1; rs2_use = 1'b1;
        dec.op1 = rs1_data_i; dec.op2 = rs2_data_i; dec.imm = b_imm;
        dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JAL: begin
        has_rd = 1'b1;
        dec.op1 = pc_i; dec.op2 = XLEN'(4); dec.imm = j_imm;
      end
      OPC_JALR: begin
        rs1_use = 1'b1; has_rd = 1'b1;
        dec.op1 = pc_i; dec.op2 = XLEN'(4); dec.imm = i_imm;
        dec.illegal = (f3 != 3'b000);
      end
      OPC_LUI: begin
        has_rd = 1'b1;
        dec.op2 = u_imm; dec.imm = u_imm;
      end
      OPC_AUIPC: begin
        has_rd = 1'b1;
        dec.op1 = pc_i; dec.op2 = u_imm; dec.imm = u_imm;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal entries still flow to EX for the trap, but must not touch state.
    dec.rd      = has_rd ? inst_i[11:7] : 5'd0;
    dec.reg_wen = has_rd && (inst_i[11:7] != 5'd0) && !dec.illegal;
    dec.mem_ren = dec.mem_ren && !dec.illegal;
    dec.mem_wen = dec.mem_wen && !dec.illegal;
    dec.word_op = dec.word_op && !dec.illegal;
  end

  assign rs1_addr_o = (in_valid_i && rs1_use) ? inst_i[19:15] : 5'd0;
  assign rs2_addr_o = (in_valid_i && rs2_use) ? inst_i[24:20] : 5'd0;

  // Unused source fields already read as x0, so a plain compare covers "used, nonzero".
  assign hazard     = in_valid_i && ex_load_valid_i && (ex_load_rd_i != 5'd0) &&
                      ((ex_load_rd_i == rs1_addr_o) || (ex_load_rd_i == rs2_addr_o));
  assign in_ready_o = (!vld_q || out_ready_i) && !hazard && !flush_i;
  assign capture    = in_valid_i && in_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q           <= '0;
      vld_q       <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      if (hazard && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
      if (capture) q <= dec;
      if (flush_i)          vld_q <= 1'b0;
      else if (capture)     vld_q <= 1'b1;
      else if (out_ready_i) vld_q <= 1'b0;
    end
  end

  assign out_valid_o = vld_q;
  assign inst_o      = q.inst;
  assign pc_o        = q.pc;
  assign op1_o       = q.op1;
  assign op2_o       = q.op2;
  assign imm_o       = q.imm;
  assign rs1_val_o   = q.rs1_val;
  assign rs2_val_o   = q.rs2_val;
  assign rd_addr_o   = q.rd;
  assign reg_wen_o   = q.reg_wen;
  assign mem_ren_o   = q.mem_ren;
  assign mem_wen_o   = q.mem_wen;
  assign word_op_o   = q.word_op;
  assign illegal_o   = q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios on XLEN=64 and XLEN=32 instances, then
// randomized traffic on the 64-bit instance against a spec-level decode/handshake model.
module tb_id_stage_pipe;
  logic        clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  // XLEN=64 instance
  logic        in_valid, flush, ex_ldv, out_ready;
  logic [31:0] inst;
  logic [63:0] pc, r1, r2;
  logic [4:0]  ex_ldrd;
  logic        in_ready, out_valid, reg_wen, mem_ren, mem_wen, word_op, illegal;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] inst_q;
  logic [63:0] pc_q, op1, op2, imm, rs1_val, rs2_val;
  logic [31:0] stall_cnt;

  // XLEN=32 instance with a narrow counter so saturation is reachable
  logic        d_valid, d_ldv;
  logic [31:0] d_inst;
  logic [4:0]  d_ldrd;
  logic        d_in_ready, d_out_valid, d_reg_wen, d_mem_ren, d_mem_wen, d_word_op, d_illegal;
  logic [4:0]  d_rs1_addr, d_rs2_addr, d_rd_addr;
  logic [31:0] d_inst_q, d_pc_q, d_op1, d_op2, d_imm, d_rs1_val, d_rs2_val;
  logic [3:0]  d_stall_cnt;

  int checks = 0, errors = 0;

  id_stage_pipe #(.XLEN(64), .STALL_CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready), .inst_i(inst),
    .pc_i(pc), .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr), .rs1_data_i(r1), .rs2_data_i(r2),
    .ex_load_valid_i(ex_ldv), .ex_load_rd_i(ex_ldrd), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .inst_o(inst_q), .pc_o(pc_q), .op1_o(op1), .op2_o(op2), .imm_o(imm),
    .rs1_val_o(rs1_val), .rs2_val_o(rs2_val), .rd_addr_o(rd_addr), .reg_wen_o(reg_wen),
    .mem_ren_o(mem_ren), .mem_wen_o(mem_wen), .word_op_o(word_op), .illegal_o(illegal),
    .stall_cnt_o(stall_cnt));

  id_stage_pipe #(.XLEN(32), .STALL_CNT_W(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(d_valid), .in_ready_o(d_in_ready), .inst_i(d_inst),
    .pc_i(32'h0000_2000), .rs1_addr_o(d_rs1_addr), .rs2_addr_o(d_rs2_addr),
    .rs1_data_i(32'h0000_0011), .rs2_data_i(32'h0000_0022), .ex_load_valid_i(d_ldv),
    .ex_load_rd_i(d_ldrd), .flush_i(1'b0), .out_valid_o(d_out_valid), .out_ready_i(1'b1),
    .inst_o(d_inst_q), .pc_o(d_pc_q), .op1_o(d_op1), .op2_o(d_op2), .imm_o(d_imm),
    .rs1_val_o(d_rs1_val), .rs2_val_o(d_rs2_val), .rd_addr_o(d_rd_addr), .reg_wen_o(d_reg_wen),
    .mem_ren_o(d_mem_ren), .mem_wen_o(d_mem_wen), .word_op_o(d_word_op), .illegal_o(d_illegal),
    .stall_cnt_o(d_stall_cnt));

  localparam logic [31:0] ADDI = 32'hFFF10093, LUI = 32'h800002B7, ADD = 32'h004101B3,
                          SD = 32'h00113423, ADDIW = 32'h0011009B, SLLI32 = 32'h02011093;

  typedef struct {
    logic [63:0] op1, op2, imm;
    logic [4:0]  rd, rs1a, rs2a;
    logic        reg_wen, mem_ren, mem_wen, word_op, illegal;
  } exp_t;

  // Immediates are rebuilt arithmetically: unsigned field value minus 2^width when the sign bit is set.
  function automatic exp_t ref_dec(input logic [31:0] w, input logic [63:0] p, a, b, input int xlen);
    exp_t e;
    longint ii, si, bi, ji, ui;
    logic [63:0] m;
    bit u1, u2, wr, wop, sh;
    int f3;
    e = '{default: 0};
    u1 = 0; u2 = 0; wr = 0; wop = 0;
    f3 = int'(w[14:12]);
    sh = (f3 == 1) || (f3 == 5);
    ii = longint'(w[31:20]) - (w[31] ? 64'sd4096 : 64'sd0);
    si = longint'({w[31:25], w[11:7]}) - (w[31] ? 64'sd4096 : 64'sd0);
    bi = longint'({w[31], w[7], w[30:25], w[11:8]}) * 2 - (w[31] ? 64'sd8192 : 64'sd0);
    ji = longint'({w[31], w[19:12], w[20], w[30:21]}) * 2 - (w[31] ? 64'sd2097152 : 64'sd0);
    ui = longint'(w[31:12]) * 4096 - (w[31] ? 64'sh1_0000_0000 : 64'sd0);
    m  = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    case (w[6:0])
      7'h13, 7'h1B: begin
        wop = (w[6:0] == 7'h1B); u1 = 1; wr = 1; e.op1 = a; e.imm = 64'(ii);
        if (sh) e.op2 = (wop || xlen == 32) ? 64'(w[24:20]) : 64'(w[25:20]);
        else    e.op2 = 64'(ii);
        e.illegal = (xlen == 32) && (wop || (sh && w[25]));
      end
      7'h33, 7'h3B: begin
        wop = (w[6:0] == 7'h3B); u1 = 1; u2 = 1; wr = 1; e.op1 = a; e.op2 = b;
        e.illegal = wop && (xlen == 32);
      end
      7'h03: begin u1 = 1; wr = 1; e.op1 = a; e.op2 = 64'(ii); e.imm = 64'(ii); e.mem_ren = 1; end
      7'h23: begin u1 = 1; u2 = 1; e.op1 = a; e.op2 = 64'(si); e.imm = 64'(si); e.mem_wen = 1; end
      7'h63: begin u1 = 1; u2 = 1; e.op1 = a; e.op2 = b; e.imm = 64'(bi); e.illegal = (f3 == 2 || f3 == 3); end
      7'h6F: begin wr = 1; e.op1 = p; e.op2 = 64'd4; e.imm = 64'(ji); end
      7'h67: begin u1 = 1; wr = 1; e.op1 = p; e.op2 = 64'd4; e.imm = 64'(ii); e.illegal = (f3 != 0); end
      7'h37: begin wr = 1; e.op2 = 64'(ui); e.imm = 64'(ui); end
      7'h17: begin wr = 1; e.op1 = p; e.op2 = 64'(ui); e.imm = 64'(ui); end
      default: e.illegal = 1;
    endcase
    e.op1 &= m; e.op2 &= m; e.imm &= m;
    e.rs1a    = u1 ? w[19:15] : 5'd0;
    e.rs2a    = u2 ? w[24:20] : 5'd0;
    e.rd      = wr ? w[11:7] : 5'd0;
    e.reg_wen = wr && (w[11:7] != 0) && !e.illegal;
    e.mem_ren = e.mem_ren && !e.illegal;
    e.mem_wen = e.mem_wen && !e.illegal;
    e.word_op = wop && !e.illegal;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [63:0] p, a, b,
                       input logic ldv, input logic [4:0] ldrd, input logic fl, input logic ordy);
    in_valid = v; inst = w; pc = p; r1 = a; r2 = b; ex_ldv = ldv; ex_ldrd = ldrd;
    flush = fl; out_ready = ordy;
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    d_valid = 0; d_inst = 0; d_ldv = 0; d_ldrd = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    checks++; if ({inst_q, op1, op2, imm} !== '0) begin errors++; $display("FAIL reset_payload: got %h %h %h %h want 0", inst_q, op1, op2, imm); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_addi_lui;
    drive(1, ADDI, 64'h1000, 64'd5, 64'd9, 0, 0, 0, 1);
    #1;
    checks++; if ({in_ready, rs1_addr, rs2_addr} !== {1'b1, 5'd2, 5'd0}) begin errors++; $display("FAIL addi_issue: got %b %0d %0d want 1 2 0", in_ready, rs1_addr, rs2_addr); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    checks++; if (op1 !== 64'd5) begin errors++; $display("FAIL addi_op1: got %h want 5", op1); end
    checks++; if (op2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL addi_op2: got %h want all ones", op2); end
    checks++; if ({rd_addr, reg_wen, pc_q} !== {5'd1, 1'b1, 64'h1000}) begin errors++; $display("FAIL addi_rd: got %0d %b %h want 1 1 1000", rd_addr, reg_wen, pc_q); end
    @(negedge clk);
    drive(1, LUI, 64'h2000, 64'h1234, 64'h5678, 0, 0, 0, 1);
    #1;
    checks++; if ({in_ready, rs1_addr} !== {1'b1, 5'd0}) begin errors++; $display("FAIL lui_issue: got %b %0d want 1 0", in_ready, rs1_addr); end
    @(posedge clk); #1;
    checks++; if (op2 !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL lui_op2: got %h want ffffffff80000000", op2); end
    checks++; if ({op1, rd_addr} !== {64'd0, 5'd5}) begin errors++; $display("FAIL lui_op1_rd: got %h %0d want 0 5", op1, rd_addr); end
  endtask

  task automatic test_hazard;
    @(negedge clk);
    drive(1, ADD, 64'h3000, 64'd100, 64'd200, 1, 5'd2, 0, 1);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_ready[%0d]: got %b want 0", c, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hazard_bubble[%0d]: got %b want 0", c, out_valid); end
      @(negedge clk);
    end
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL hazard_cnt: got %0d want 3", stall_cnt); end
    ex_ldv = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_release: got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if ({out_valid, rd_addr, op1, op2} !== {1'b1, 5'd3, 64'd100, 64'd200}) begin errors++; $display("FAIL hazard_capture: got %b %0d %0d %0d want 1 3 100 200", out_valid, rd_addr, op1, op2); end
  endtask

  task automatic test_hold;
    @(negedge clk);
    drive(1, SD, 64'h4000, 64'h40, 64'hDEAD, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", c, in_ready); end
      @(posedge clk); #1;
      checks++; if ({out_valid, inst_q, op1, pc_q} !== {1'b1, ADD, 64'd100, 64'h3000}) begin errors++; $display("FAIL hold_payload[%0d]: got %b %h %0d %h", c, out_valid, inst_q, op1, pc_q); end
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if ({inst_q, mem_wen, reg_wen, imm, op2} !== {SD, 1'b1, 1'b0, 64'd8, 64'd8}) begin errors++; $display("FAIL sd_decode: got %h %b %b %0d %0d want sd 1 0 8 8", inst_q, mem_wen, reg_wen, imm, op2); end
    checks++; if ({op1, rs2_val} !== {64'h40, 64'hDEAD}) begin errors++; $display("FAIL sd_data: got %h %h want 40 dead", op1, rs2_val); end
  endtask

  task automatic test_flush_reset;
    @(negedge clk);
    drive(1, ADDI, 64'h5000, 64'd7, 64'd0, 0, 0, 1, 0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    @(negedge clk);
    drive(0, ADDI, 64'h5000, 64'd7, 64'd0, 0, 0, 0, 1);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_nocapture: got %b want 0", out_valid); end
    @(negedge clk);
    drive(1, ADDI, 64'h6000, 64'd7, 64'd0, 0, 0, 0, 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    checks++; if ({out_valid, reg_wen, inst_q, op1, stall_cnt} !== '0) begin errors++; $display("FAIL midreset: got %b %b %h %h %0d want 0", out_valid, reg_wen, inst_q, op1, stall_cnt); end
    @(negedge clk);
    rst_n = 1; in_valid = 0;
  endtask

  task automatic test_word_ops;
    @(negedge clk);
    drive(1, ADDIW, 64'h7000, 64'd50, 64'd0, 0, 0, 0, 1);
    d_valid = 1; d_inst = ADDIW;
    @(posedge clk); #1;
    checks++; if ({word_op, op2, reg_wen, illegal} !== {1'b1, 64'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL addiw64: got %b %0d %b %b want 1 1 1 0", word_op, op2, reg_wen, illegal); end
    checks++; if ({d_out_valid, d_illegal, d_reg_wen, d_word_op} !== 4'b1100) begin errors++; $display("FAIL addiw32: got %b%b%b%b want 1100", d_out_valid, d_illegal, d_reg_wen, d_word_op); end
    @(negedge clk);
    inst = SLLI32; d_inst = SLLI32;
    @(posedge clk); #1;
    checks++; if ({op2, illegal, reg_wen} !== {64'd32, 1'b0, 1'b1}) begin errors++; $display("FAIL slli64: got %0d %b %b want 32 0 1", op2, illegal, reg_wen); end
    checks++; if ({d_illegal, d_reg_wen} !== 2'b10) begin errors++; $display("FAIL slli32: got %b%b want 10", d_illegal, d_reg_wen); end
    @(negedge clk);
    in_valid = 0; d_valid = 0;
  endtask

  task automatic test_saturate;
    d_valid = 1; d_inst = ADD; d_ldv = 1; d_ldrd = 5'd4;
    repeat (20) @(posedge clk);
    #1;
    checks++; if ({d_stall_cnt, d_in_ready} !== {4'hF, 1'b0}) begin errors++; $display("FAIL stall_saturate: got %0d %b want 15 0", d_stall_cnt, d_in_ready); end
    @(negedge clk);
    d_valid = 0; d_ldv = 0;
  endtask

  task automatic test_random;
    logic [6:0]  opcs [11] = '{7'h13, 7'h1B, 7'h33, 7'h3B, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    bit          mv = 0, hz, rdy;
    exp_t        e, me;
    logic [31:0] mi, w;
    logic [63:0] mpc, ma, mb;
    longint      mcnt = 0;
    int          k;
    rst_n = 0; #2; rst_n = 1;
    me = '{default: 0}; mi = 0; mpc = 0; ma = 0; mb = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      k = $urandom_range(0, 11);
      w = $urandom;
      if (k < 11) begin w[6:0] = opcs[k]; w[19:15] = 5'($urandom_range(0, 7)); w[24:20] = 5'($urandom_range(0, 7)); end
      drive($urandom_range(0, 3) != 0, w, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0);
      e = ref_dec(inst, pc, r1, r2, 64);
      if (!in_valid) begin e.rs1a = 0; e.rs2a = 0; end
      hz  = in_valid && ex_ldv && ex_ldrd != 0 && (ex_ldrd == e.rs1a || ex_ldrd == e.rs2a);
      rdy = (!mv || out_ready) && !hz && !flush;
      #1;
      checks++; if ({in_ready, rs1_addr, rs2_addr} !== {rdy, e.rs1a, e.rs2a}) begin errors++; $display("FAIL rnd_issue[%0d]: got %b %0d %0d want %b %0d %0d", n, in_ready, rs1_addr, rs2_addr, rdy, e.rs1a, e.rs2a); end
      if (hz) mcnt++;
      if (flush) mv = 0;
      else if (in_valid && rdy) begin mv = 1; me = e; mi = inst; mpc = pc; ma = r1; mb = r2; end
      else if (out_ready) mv = 0;
      @(posedge clk); #1;
      checks++; if ({out_valid, stall_cnt} !== {mv, 32'(mcnt)}) begin errors++; $display("FAIL rnd_valid_cnt[%0d]: got %b %0d want %b %0d", n, out_valid, stall_cnt, mv, mcnt); end
      if (mv) begin
        checks++; if ({inst_q, pc_q, rs1_val, rs2_val} !== {mi, mpc, ma, mb}) begin errors++; $display("FAIL rnd_pass[%0d]: got %h %h want %h %h", n, inst_q, pc_q, mi, mpc); end
        checks++; if ({op1, op2, imm} !== {me.op1, me.op2, me.imm}) begin errors++; $display("FAIL rnd_ops[%0d] inst %h: got %h %h %h want %h %h %h", n, mi, op1, op2, imm, me.op1, me.op2, me.imm); end
        checks++; if ({rd_addr, reg_wen, mem_ren, mem_wen, word_op, illegal} !== {me.rd, me.reg_wen, me.mem_ren, me.mem_wen, me.word_op, me.illegal}) begin errors++; $display("FAIL rnd_ctl[%0d] inst %h: got %0d %b%b%b%b%b want %0d %b%b%b%b%b", n, mi, rd_addr, reg_wen, mem_ren, mem_wen, word_op, illegal, me.rd, me.reg_wen, me.mem_ren, me.mem_wen, me.word_op, me.illegal); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_addi_lui;
    test_hazard;
    test_hold;
    test_flush_reset;
    test_word_ops;
    test_saturate;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end
endmodule
